// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: parametrised pipeline stall/flush controller with deferred flush and stall watchdog
module pipe_ctrl_gen #(
  parameter int unsigned               NUM_STAGES = 9,
  parameter int unsigned               NUM_REQ    = 4,
  parameter logic [4*NUM_REQ-1:0]      REQ_DEPTH  = {4'd8, 4'd5, 4'd4, 4'd3},
  parameter logic [NUM_REQ-1:0]        FLUSH_BLOCK = 4'b1000,
  parameter logic [31:0]               EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0]               ERET_CODE  = 32'h0000000E,
  parameter int unsigned               CNT_W      = 16,
  parameter logic [CNT_W-1:0]          TIMEOUT    = 16'd4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    stallreq_i,
  input  logic [31:0]           excepttype_i,
  input  logic [31:0]           cp0_epc_i,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush_pending,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  stall_timeout
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_STAGES-1:0] merge;
  logic                  blocked, exc, flush_c;
  logic [31:0]           tgt, new_pc_c;

  // prefix masks per active requester; deepest active request dominates
  always_comb begin
    merge = '0;
    for (int r = 0; r < int'(NUM_REQ); r++)
      for (int k = 0; k < int'(NUM_STAGES); k++)
        if (stallreq_i[r] && k < int'(REQ_DEPTH[r*4 +: 4])) merge[k] = 1'b1;
  end

  // flush decision: immediate when unblocked, otherwise capture target and wait for the blocker to drop
  always_comb begin
    blocked  = |(stallreq_i & FLUSH_BLOCK);
    exc      = excepttype_i != 32'd0;
    tgt      = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    state_d  = state_q;
    pc_d     = pc_q;
    flush_c  = 1'b0;
    new_pc_c = 32'd0;
    if (state_q == IDLE) begin
      if (exc && !blocked) begin
        flush_c  = 1'b1;
        new_pc_c = tgt;
      end else if (exc) begin
        state_d = PEND;
        pc_d    = tgt;
      end
    end else if (!blocked) begin
      flush_c  = 1'b1;
      new_pc_c = pc_q;
      state_d  = IDLE;
    end
  end

  // outputs held at zero during reset; a flush overrides any non-blocking stall
  always_comb begin
    flush         = resetn & flush_c;
    new_pc        = resetn ? new_pc_c : 32'd0;
    stall         = (resetn && !flush_c) ? merge : '0;
    flush_pending = state_q == PEND;
    stall_cnt     = cnt_q;
    stall_timeout = timeout_q;
    cnt_d         = (stall != '0) ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : '0;
    timeout_d     = timeout_q | ((stall != '0) && (cnt_q == TIMEOUT - 1'b1));
  end

  // state registers; reset also discards any pending flush
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pc_q      <= 32'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
- Parametrised pipeline stall/flush controller for the CPU core; the next generation of the fixed 4-requester, 9-stage controller.
- Merges N stall requests into a per-stage stall vector, using a configurable stage depth per requester.
- Generates exception/ERET flush with redirect PC, and defers a flush while a blocking requester (e.g. D-cache miss in flight) holds the pipe.
- Tracks consecutive stall cycles and raises a sticky watchdog flag.

Parameters:
- NUM_STAGES, 9: width of stall vector; bit 0 = PC stage, bit k = stage k.
- NUM_REQ, 4: number of stall requesters; index 0 = lowest priority (IC), NUM_REQ-1 = highest (DC).
- REQ_DEPTH, {4'd8,4'd5,4'd4,4'd3}: packed 4-bit per requester; requester r stalls stages [0 .. REQ_DEPTH[r]-1]; each value 1..NUM_STAGES.
- FLUSH_BLOCK, 4'b1000: per requester; 1 = flush must wait until this request drops.
- EXC_VECTOR, 32'hBFC00380: redirect PC for non-ERET exceptions.
- ERET_CODE, 32'h0000000E: excepttype value meaning ERET (redirect to EPC).
- CNT_W, 16: stall counter width.
- TIMEOUT, 16'd4096: consecutive stall cycles that set stall_timeout.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- stallreq_i  in  NUM_REQ  stall requests, level, bit r per requester.
- excepttype_i  in  32  exception type from MEM stage; nonzero = exception.
- cp0_epc_i  in  32  EPC from CP0.
- flush  out  1  pipeline flush.
- new_pc  out  32  redirect PC, valid when flush=1, else 0.
- stall  out  NUM_STAGES  per-stage hold.
- flush_pending  out  1  exception captured, flush deferred.
- stall_cnt  out  CNT_W  consecutive stall cycles.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (resetn=0, async): stall=0, flush=0, new_pc=0, flush_pending=0, stall_cnt=0, stall_timeout=0. Combinational outputs are forced to these values while resetn=0. A pending flush is discarded.
- Stall merge (combinational):
  - stall = bitwise OR over active r of the mask with ones in bits [REQ_DEPTH[r]-1:0].
  - Masks are prefixes, so the deepest active request wins; this reproduces the previous priority (DC>EX>ID>IC).
- blocked = |(stallreq_i & FLUSH_BLOCK).
- Target: tgt = (excepttype_i==ERET_CODE) ? cp0_epc_i : EXC_VECTOR.
- Immediate flush: excepttype_i!=0, blocked=0, flush_pending=0.
  - Same cycle: flush=1, new_pc=tgt, stall forced to 0 (flush overrides non-blocking requests).
- Deferred flush: excepttype_i!=0 and blocked=1, flush_pending=0.
  - Capture tgt into pc_q and set flush_pending at the clock edge.
  - flush stays 0 and stall follows the merge.
- Pending state:
  - excepttype_i and cp0_epc_i are ignored; the first capture wins.
  - In the first cycle with blocked=0: flush=1, new_pc=pc_q, stall=0.
  - flush_pending clears at the end of that cycle.
  - Flush latency after the blocker drops: 0 cycles.
- States: IDLE (flush_pending=0) -> PEND on deferred capture; PEND -> IDLE on pending flush issue. An exception in the issue cycle is not re-captured (pipe is flushed).
- stall_cnt:
  - Increments each cycle stall!=0, saturating at all ones.
  - Clears to 0 in any cycle where stall==0 or flush=1.
- stall_timeout: set when stall_cnt reaches TIMEOUT-1 and stall is still nonzero. Cleared only by reset.
- Outputs not named in a rule: flush=0, new_pc=0.

Test Plan:
- Reset: hold resetn=0 with stallreq_i=4'hF and excepttype_i=1 -> stall=0, flush=0, new_pc=0, all state 0. Release resetn -> stall=9'h0FF next evaluation.
- Priority merge, one request at a time:
  - stallreq_i=4'b0001 -> stall=9'h007.
  - 4'b0010 -> 9'h00F.
  - 4'b0100 -> 9'h01F.
  - 4'b0110 -> 9'h01F.
  - 4'b1000 -> 9'h0FF.
- Immediate flush:
  - stallreq_i=4'b0100, excepttype_i=32'h1 -> same cycle flush=1, new_pc=32'hBFC00380, stall=0.
  - excepttype_i=32'hE, cp0_epc_i=32'h80001234 -> new_pc=32'h80001234.
- Deferred flush:
  - stallreq_i=4'b1000 with excepttype_i=32'hE, EPC=32'h80000040 for 1 cycle, then EPC changes and excepttype_i=0 -> flush_pending=1, flush=0 for 3 stall cycles.
  - Drop stallreq -> flush=1, new_pc=32'h80000040 that cycle; flush_pending=0 next cycle.
- Reset mid-pending: deassert resetn while flush_pending=1 -> after release, flush never asserts on blocker drop.
- Watchdog: TIMEOUT=16'd8, hold stallreq_i=4'b0001 -> stall_cnt counts 1..8; stall_timeout=1 after the 8th stall cycle. Drop the request -> stall_cnt=0, stall_timeout stays 1.
